// File: rtl/map_table_pkg.sv
// map_table_pkg: shared rename-stage definitions.
// Holds the register-file geometry and the packet/struct types that the map
// table, free list and reservation station agree on. A packet-port wrapper
// can adopt the ID/MT/CDB packets without touching the map table itself.
package map_table_pkg;

    localparam int ARCH_REG_SZ = 32;
    localparam int PHYS_REG_SZ = 64;
    localparam int TAG_W       = $clog2(PHYS_REG_SZ);
    localparam int AREG_W      = $clog2(ARCH_REG_SZ);

    // Physical tag with status, shared with the free list and RS.
    typedef struct packed {
        logic [TAG_W-1:0] phys_reg;
        logic             valid;
        logic             ready;
    } PHYS_TAG;

    // Dispatch stage -> map table request.
    typedef struct packed {
        logic              dispatch_en;
        logic [AREG_W-1:0] rs1_idx;
        logic [AREG_W-1:0] rs2_idx;
        logic [AREG_W-1:0] rd_idx;
        logic              rd_valid;
    } ID_MT_PACKET;

    // Map table -> dispatch stage response.
    typedef struct packed {
        PHYS_TAG t1;
        PHYS_TAG t2;
        PHYS_TAG t_old;
        logic    stall;
    } MT_ID_PACKET;

    // Common data bus broadcast.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } CDB_PACKET;

    // Extract entry i of a flattened architectural map.
    function automatic logic [TAG_W-1:0] arch_entry(
        input logic [ARCH_REG_SZ*TAG_W-1:0] flat_map,
        input int unsigned                  idx
    );
        return flat_map[idx*TAG_W +: TAG_W];
    endfunction

endpackage

// File: rtl/map_table.sv
// map_table: R10K-style register rename map.
// Per architectural register it keeps the current physical tag and a ready
// bit. Sources are looked up combinationally (with CDB bypass on the ready
// bit), the destination's previous tag is reported as T_old, and on dispatch
// the free-list tag becomes the new mapping. Rollback reloads the table from
// the retirement map.
//
// Ports:
//   clock, reset              clock and synchronous active-high reset
//   dispatch_en, rs1/rs2/rd   rename request for one instruction
//   rd_valid                  instruction writes rd
//   free_tag, free_valid      tag offered by the free list
//   cdb_valid, cdb_tag        completion broadcast
//   rollback_en, arch_map     recovery request and retirement map
//   t1_*, t2_*                source mappings and readiness
//   t_old_tag, t_old_valid    previous mapping of rd (valid => rename happens)
//   stall                     rd needs a tag but none is free
module map_table
    import map_table_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         dispatch_en,
    input  logic [AREG_W-1:0]            rs1_idx,
    input  logic [AREG_W-1:0]            rs2_idx,
    input  logic [AREG_W-1:0]            rd_idx,
    input  logic                         rd_valid,
    input  logic [TAG_W-1:0]             free_tag,
    input  logic                         free_valid,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic                         rollback_en,
    input  logic [ARCH_REG_SZ*TAG_W-1:0] arch_map,
    output logic [TAG_W-1:0]             t1_tag,
    output logic                         t1_ready,
    output logic [TAG_W-1:0]             t2_tag,
    output logic                         t2_ready,
    output logic [TAG_W-1:0]             t_old_tag,
    output logic                         t_old_valid,
    output logic                         stall
);

    logic [TAG_W-1:0]       r_map [ARCH_REG_SZ];
    logic [ARCH_REG_SZ-1:0] r_rdy;
    logic                   w_rd_needs_tag;

    // Lookups and rename control; all combinational from the current table.
    always_comb begin
        t1_tag         = r_map[rs1_idx];
        t2_tag         = r_map[rs2_idx];
        t_old_tag      = r_map[rd_idx];
        // A tag completing this very cycle counts as ready for the sources.
        t1_ready       = r_rdy[rs1_idx] | (cdb_valid & (cdb_tag == r_map[rs1_idx]));
        t2_ready       = r_rdy[rs2_idx] | (cdb_valid & (cdb_tag == r_map[rs2_idx]));
        // x0 is never renamed, so it never consumes a free tag.
        w_rd_needs_tag = dispatch_en & rd_valid & (rd_idx != {AREG_W{1'b0}});
        stall          = w_rd_needs_tag & ~free_valid;
        t_old_valid    = w_rd_needs_tag & free_valid & ~rollback_en;
    end

    // Table update: reset > rollback > rename > CDB wakeup.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REG_SZ; i++) begin
                r_map[i] <= TAG_W'(i);
                r_rdy[i] <= 1'b1;
            end
        end else if (rollback_en) begin
            for (int i = 0; i < ARCH_REG_SZ; i++) begin
                r_map[i] <= arch_entry(arch_map, i);
                r_rdy[i] <= 1'b1;
            end
        end else begin
            if (cdb_valid) begin
                for (int i = 0; i < ARCH_REG_SZ; i++) begin
                    if (r_map[i] == cdb_tag) begin
                        r_rdy[i] <= 1'b1;
                    end
                end
            end
            // Placed after the CDB loop so a rename of the same entry wins.
            if (t_old_valid) begin
                r_map[rd_idx] <= free_tag;
                r_rdy[rd_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_map_table.sv
module tb_map_table;
    import map_table_pkg::*;

    logic                         clock = 1'b0;
    logic                         reset = 1'b1;
    logic                         dispatch_en = 1'b0;
    logic [AREG_W-1:0]            rs1_idx = '0;
    logic [AREG_W-1:0]            rs2_idx = '0;
    logic [AREG_W-1:0]            rd_idx = '0;
    logic                         rd_valid = 1'b0;
    logic [TAG_W-1:0]             free_tag = '0;
    logic                         free_valid = 1'b0;
    logic                         cdb_valid = 1'b0;
    logic [TAG_W-1:0]             cdb_tag = '0;
    logic                         rollback_en = 1'b0;
    logic [ARCH_REG_SZ*TAG_W-1:0] arch_map;
    logic [TAG_W-1:0]             t1_tag, t2_tag, t_old_tag;
    logic                         t1_ready, t2_ready, t_old_valid, stall;

    map_table dut (
        .clock       (clock),
        .reset       (reset),
        .dispatch_en (dispatch_en),
        .rs1_idx     (rs1_idx),
        .rs2_idx     (rs2_idx),
        .rd_idx      (rd_idx),
        .rd_valid    (rd_valid),
        .free_tag    (free_tag),
        .free_valid  (free_valid),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .rollback_en (rollback_en),
        .arch_map    (arch_map),
        .t1_tag      (t1_tag),
        .t1_ready    (t1_ready),
        .t2_tag      (t2_tag),
        .t2_ready    (t2_ready),
        .t_old_tag   (t_old_tag),
        .t_old_valid (t_old_valid),
        .stall       (stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [21:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Monitor: outputs are combinational, presented every cycle; check mid-cycle.
    initial begin
        sb_t         e;
        logic [21:0] act;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {t1_tag, t1_ready, t2_tag, t2_ready, t_old_tag, t_old_valid, stall};
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got t1=%0d/%b t2=%0d/%b told=%0d/%b stall=%b, required t1=%0d/%b t2=%0d/%b told=%0d/%b stall=%b",
                             e.name, act[21:16], act[15], act[14:9], act[8], act[7:2], act[1], act[0],
                             e.exp[21:16], e.exp[15], e.exp[14:9], e.exp[8], e.exp[7:2], e.exp[1], e.exp[0]);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue the expected combinational outputs.
    task automatic step(
        input string             nm,
        input logic              rst, input logic disp,
        input logic [AREG_W-1:0] rs1, input logic [AREG_W-1:0] rs2,
        input logic [AREG_W-1:0] rd,  input logic rdv,
        input logic [TAG_W-1:0]  ft,  input logic fv,
        input logic              cv,  input logic [TAG_W-1:0] ct,
        input logic              rb,
        input logic [TAG_W-1:0]  e1, input logic r1,
        input logic [TAG_W-1:0]  e2, input logic r2,
        input logic [TAG_W-1:0]  eo, input logic ov,
        input logic              es
    );
        sb_t e;
        @(posedge clock);
        #1;
        reset = rst; dispatch_en = disp; rs1_idx = rs1; rs2_idx = rs2;
        rd_idx = rd; rd_valid = rdv; free_tag = ft; free_valid = fv;
        cdb_valid = cv; cdb_tag = ct; rollback_en = rb;
        e.name = nm;
        e.exp  = {e1, r1, e2, r2, eo, ov, es};
        sb.push_back(e);
    endtask

    task automatic set_identity();
        for (int i = 0; i < ARCH_REG_SZ; i++) begin
            arch_map[i*TAG_W +: TAG_W] = TAG_W'(i);
        end
    endtask

    initial begin
        set_identity();
        repeat (2) @(posedge clock);
        //    name          rst  dsp  rs1    rs2    rd     rdv  ftag   fv   cv   ctag   rb    t1   r1   t2   r2   told  ov   st
        step("reset_zero",  1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,6'd0, 1'b0,1'b0,6'd0, 1'b0, 6'd0,1'b1,6'd0,1'b1,6'd0,1'b0,1'b0);
        step("reset_ident", 1'b0,1'b0,5'd5, 5'd7, 5'd3, 1'b0,6'd0, 1'b0,1'b0,6'd0, 1'b0, 6'd5,1'b1,6'd7,1'b1,6'd3,1'b0,1'b0);
        step("rename_3_40", 1'b0,1'b1,5'd3, 5'd3, 5'd3, 1'b1,6'd40,1'b1,1'b0,6'd0, 1'b0, 6'd3,1'b1,6'd3,1'b1,6'd3,1'b1,1'b0);
        step("read_3_busy", 1'b0,1'b0,5'd3, 5'd4, 5'd0, 1'b0,6'd0, 1'b0,1'b0,6'd0, 1'b0, 6'd40,1'b0,6'd4,1'b1,6'd0,1'b0,1'b0);
        step("cdb_bypass",  1'b0,1'b0,5'd3, 5'd3, 5'd0, 1'b0,6'd0, 1'b0,1'b1,6'd40,1'b0, 6'd40,1'b1,6'd40,1'b1,6'd0,1'b0,1'b0);
        step("cdb_written", 1'b0,1'b0,5'd3, 5'd0, 5'd0, 1'b0,6'd0, 1'b0,1'b0,6'd0, 1'b0, 6'd40,1'b1,6'd0,1'b1,6'd0,1'b0,1'b0);
        step("rs_eq_rd",    1'b0,1'b1,5'd3, 5'd3, 5'd3, 1'b1,6'd41,1'b1,1'b1,6'd40,1'b0, 6'd40,1'b1,6'd40,1'b1,6'd40,1'b1,1'b0);
        step("read_3_41",   1'b0,1'b0,5'd3, 5'd5, 5'd0, 1'b0,6'd0, 1'b0,1'b0,6'd0, 1'b0, 6'd41,1'b0,6'd5,1'b1,6'd0,1'b0,1'b0);
        step("rename_wins", 1'b0,1'b1,5'd3, 5'd0, 5'd3, 1'b1,6'd42,1'b1,1'b1,6'd41,1'b0, 6'd41,1'b1,6'd0,1'b1,6'd41,1'b1,1'b0);
        step("x0_dispatch", 1'b0,1'b1,5'd3, 5'd0, 5'd0, 1'b1,6'd50,1'b1,1'b0,6'd0, 1'b0, 6'd42,1'b0,6'd0,1'b1,6'd0,1'b0,1'b0);
        step("stall_6",     1'b0,1'b1,5'd0, 5'd3, 5'd6, 1'b1,6'd51,1'b0,1'b0,6'd0, 1'b0, 6'd0,1'b1,6'd42,1'b0,6'd6,1'b0,1'b1);
        step("no_write",    1'b0,1'b0,5'd6, 5'd0, 5'd6, 1'b0,6'd0, 1'b0,1'b0,6'd0, 1'b0, 6'd6,1'b1,6'd0,1'b1,6'd6,1'b0,1'b0);
        step("rename_6_43", 1'b0,1'b1,5'd6, 5'd0, 5'd6, 1'b1,6'd43,1'b1,1'b0,6'd0, 1'b0, 6'd6,1'b1,6'd0,1'b1,6'd6,1'b1,1'b0);
        step("cdb_43",      1'b0,1'b0,5'd6, 5'd3, 5'd0, 1'b0,6'd0, 1'b0,1'b1,6'd43,1'b0, 6'd43,1'b1,6'd42,1'b0,6'd0,1'b0,1'b0);
        step("pre_rollback",1'b0,1'b0,5'd6, 5'd3, 5'd0, 1'b0,6'd0, 1'b0,1'b0,6'd0, 1'b0, 6'd43,1'b1,6'd42,1'b0,6'd0,1'b0,1'b0);
        step("rollback",    1'b0,1'b1,5'd3, 5'd6, 5'd2, 1'b1,6'd44,1'b1,1'b0,6'd0, 1'b1, 6'd42,1'b0,6'd43,1'b1,6'd2,1'b0,1'b0);
        step("post_rb_a",   1'b0,1'b0,5'd3, 5'd2, 5'd6, 1'b0,6'd0, 1'b0,1'b0,6'd0, 1'b0, 6'd3,1'b1,6'd2,1'b1,6'd6,1'b0,1'b0);
        step("post_rb_b",   1'b0,1'b0,5'd6, 5'd31,5'd0, 1'b0,6'd0, 1'b0,1'b0,6'd0, 1'b0, 6'd6,1'b1,6'd31,1'b1,6'd0,1'b0,1'b0);
        // Non-identity retirement map: entry 5 -> 60, entry 31 -> 33.
        @(posedge clock);
        arch_map[5*TAG_W +: TAG_W]  = 6'd60;
        arch_map[31*TAG_W +: TAG_W] = 6'd33;
        step("rollback_map",1'b0,1'b0,5'd5, 5'd31,5'd0, 1'b0,6'd0, 1'b0,1'b0,6'd0, 1'b1, 6'd5,1'b1,6'd31,1'b1,6'd0,1'b0,1'b0);
        step("rb_loaded",   1'b0,1'b0,5'd5, 5'd31,5'd0, 1'b0,6'd0, 1'b0,1'b0,6'd0, 1'b0, 6'd60,1'b1,6'd33,1'b1,6'd0,1'b0,1'b0);
        step("rename_5_45", 1'b0,1'b1,5'd5, 5'd0, 5'd5, 1'b1,6'd45,1'b1,1'b0,6'd0, 1'b0, 6'd60,1'b1,6'd0,1'b1,6'd60,1'b1,1'b0);
        step("in_reset",    1'b1,1'b0,5'd5, 5'd31,5'd0, 1'b0,6'd0, 1'b0,1'b0,6'd0, 1'b0, 6'd45,1'b0,6'd33,1'b1,6'd0,1'b0,1'b0);
        step("after_reset", 1'b0,1'b0,5'd5, 5'd31,5'd0, 1'b0,6'd0, 1'b0,1'b0,6'd0, 1'b0, 6'd5,1'b1,6'd31,1'b1,6'd0,1'b0,1'b0);

        // Let the monitor drain the scoreboard, bounded.
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(posedge clock);
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/map_table.md
Name: map_table

Overview:
- Register rename map for the R10K-style out-of-order core; sits in the ID (dispatch) stage next to the free list.
- Holds, per architectural register, the current physical tag and its ready bit.
- Supplies source tags T1/T2 and the T_old of the destination. Installs the free-list tag as the new mapping on dispatch.
- Marks tags ready on CDB broadcast. Restores the whole table from the retirement (architectural) map on rollback.

Parameters:
- ARCH_REG_SZ, 32, number of architectural registers.
- PHYS_REG_SZ, 64, number of physical registers.
- TAG_W, $clog2(PHYS_REG_SZ) = 6, physical tag width.
- AREG_W, $clog2(ARCH_REG_SZ) = 5, architectural index width.

Ports:
- clock  in  1  clock; reset is synchronous, active-high, named reset.
- reset  in  1  synchronous active-high reset.
- dispatch_en  in  1  rename one instruction this cycle.
- rs1_idx  in  AREG_W  source 1 architectural index.
- rs2_idx  in  AREG_W  source 2 architectural index.
- rd_idx  in  AREG_W  destination architectural index.
- rd_valid  in  1  instruction writes rd.
- free_tag  in  TAG_W  tag popped from free list this cycle.
- free_valid  in  1  free list has a tag.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  completed tag.
- rollback_en  in  1  mispredict recovery.
- arch_map  in  ARCH_REG_SZ*TAG_W  retirement map, entry i at bits [i*TAG_W +: TAG_W].
- t1_tag  out  TAG_W  mapping of rs1.
- t1_ready  out  1  rs1 value available.
- t2_tag  out  TAG_W  mapping of rs2.
- t2_ready  out  1  rs2 value available.
- t_old_tag  out  TAG_W  previous mapping of rd.
- t_old_valid  out  1  t_old_tag meaningful.
- stall  out  1  rename cannot proceed (rd needs tag, none free).

Behaviour:
- Storage: map[ARCH_REG_SZ] of TAG_W, rdy[ARCH_REG_SZ] flops.
- Reset: map[i] = i, rdy[i] = 1 for all i. This matches the free list marking tags 0..31 busy.
  - Outputs after reset with all inputs 0: t1_tag = t2_tag = t_old_tag = 0, t1_ready = t2_ready = 1, t_old_valid = 0, stall = 0.
- Reads (combinational, zero latency):
  - t1_tag = map[rs1_idx].
  - t1_ready = rdy[rs1_idx] | (cdb_valid & cdb_tag == map[rs1_idx]). CDB bypass.
  - Same rules for t2.
- Sources read the pre-dispatch mapping. rs == rd in the same instruction returns the old tag.
- t_old_tag = map[rd_idx]. t_old_valid = dispatch_en & rd_valid & rd_idx != 0 & !stall.
- stall = dispatch_en & rd_valid & rd_idx != 0 & !free_valid.
- x0:
  - Never renamed.
  - map[0] stays 0 and rdy[0] stays 1 except after reset or rollback. Rollback reloads arch_map[0], which must be 0.
  - The pop request to the free list is 0 when rd_idx == 0. This is computed outside the block as t_old_valid.
- Rename write, at the clock edge when t_old_valid: map[rd_idx] <= free_tag, rdy[rd_idx] <= 0.
- CDB, at the clock edge when cdb_valid: every entry with map[i] == cdb_tag gets rdy[i] <= 1. Normally zero or one match.
- Simultaneous rename and CDB on the same entry: the rename wins, so the entry becomes the new tag with rdy 0. cdb_tag ≠ free_tag is guaranteed by the free list.
- Rollback:
  - rollback_en has priority over dispatch and CDB in the same cycle.
  - map[i] <= arch_map[i], rdy[i] <= 1 for all i.
  - Rename and CDB updates that cycle are dropped. t_old_valid is forced to 0 while rollback_en.
- Reset has priority over everything. Reset mid-stream restores the identity map next cycle.
- No internal pipelining. Rename is visible to the next cycle's reads.

Decomposition:
- Shared package (sys_defs): ARCH_REG_SZ, PHYS_REG_SZ, TAG_W, AREG_W.
- Shared package also holds a PHYS_TAG struct {phys_reg, valid, ready}, reused by the free list and RS.
- Shared package also holds ID_MT_PACKET / MT_ID_PACKET / CDB_PACKET typedefs. A packet-port wrapper may adopt these later.
- No sub-module needed. Optional map_entry (tag + ready flop with CDB compare) instantiated ARCH_REG_SZ times.

Test Plan:
- Reset, then rs1=5, rs2=7 -> t1_tag=5, t2_tag=7, both ready=1. rd=3 -> t_old_tag=3.
- Dispatch rd=3, free_tag=40, free_valid=1 -> t_old_tag=3, t_old_valid=1. Next cycle rs1=3 -> t1_tag=40, t1_ready=0.
- With map[3]=40 not ready, cdb_valid=1, cdb_tag=40 and rs1=3 -> t1_ready=1 in the same cycle (bypass). Next cycle rdy[3]=1 without CDB.
- Dispatch rd=3, rs1=3, free_tag=41 -> t1_tag=40 (old). Same cycle cdb_tag=40 -> map[3]=41, rdy=0 next cycle.
- Dispatch rd=0 -> t_old_valid=0, map[0] unchanged. rd=6 with free_valid=0 -> stall=1, no write.
- After several renames, rollback_en with arch_map identity plus dispatch rd=2 -> next cycle map[i]=i, all ready, map[2]=2.
